// File: rtl/sm4_req_scheduler.sv
// Shares one SM4 core between two requesters: round-robin grant, key-expansion
// caching, and per-phase timeout abort. Every output comes straight from a flop.
module sm4_req_scheduler #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic         iClk,
  input  logic         iReset_n,
  input  logic         iReqA_valid,
  input  logic [127:0] iReqA_key,
  input  logic [127:0] iReqA_data,
  input  logic         iReqA_sel,
  input  logic         iReqB_valid,
  input  logic [127:0] iReqB_key,
  input  logic [127:0] iReqB_data,
  input  logic         iReqB_sel,
  output logic         oReqA_accept,
  output logic         oReqB_accept,
  output logic         oRespA_valid,
  output logic         oRespB_valid,
  output logic [127:0] oResp_data,
  output logic         oResp_err,
  output logic [127:0] oCore_key,
  output logic [127:0] oCore_data,
  output logic         oCore_sel,
  output logic         oCore_keyexp_en,
  output logic         oCore_encdec_en,
  input  logic         iCore_keyexp_ready,
  input  logic         iCore_ready,
  input  logic [127:0] iCore_result,
  output logic         oBusy,
  output logic         oKey_cached
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_KEYEXP = 2'd1;
  localparam logic [1:0] ST_CRYPT  = 2'd2;
  localparam logic [1:0] ST_RESP   = 2'd3;

  localparam int unsigned TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  // Abort on the edge where the counter would reach TIMEOUT_CYCLES-1.
  localparam logic [TW-1:0] TABORT = TW'(TIMEOUT_CYCLES - 2);

  logic [1:0]    state_q, state_d;
  logic          owner_q, owner_d;      // 0 = A, 1 = B
  logic          rr_last_q, rr_last_d;  // 0 = A, 1 = B
  logic          key_valid_q, key_valid_d;
  logic [127:0]  cache_key_q, cache_key_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [127:0]  result_q, result_d;
  logic          err_q, err_d;
  logic          acc_a_q, acc_a_d, acc_b_q, acc_b_d;
  logic          resp_a_q, resp_a_d, resp_b_q, resp_b_d;
  logic [127:0]  resp_data_q, resp_data_d;
  logic          resp_err_q, resp_err_d;
  logic [127:0]  core_key_q, core_key_d, core_data_q, core_data_d;
  logic          core_sel_q, core_sel_d;
  logic          keyexp_en_q, keyexp_en_d, encdec_en_q, encdec_en_d;
  logic          busy_q, busy_d;

  logic          grant_b;
  logic [127:0]  grant_key;
  logic          timer_hit;

  assign grant_b   = iReqB_valid && (!iReqA_valid || !rr_last_q);
  assign grant_key = grant_b ? iReqB_key : iReqA_key;
  assign timer_hit = (timer_q == TABORT);

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_last_d   = rr_last_q;
    key_valid_d = key_valid_q;
    cache_key_d = cache_key_q;
    timer_d     = timer_q;
    result_d    = result_q;
    err_d       = err_q;
    acc_a_d     = 1'b0;
    acc_b_d     = 1'b0;
    resp_a_d    = 1'b0;
    resp_b_d    = 1'b0;
    resp_data_d = resp_data_q;
    resp_err_d  = resp_err_q;
    core_key_d  = core_key_q;
    core_data_d = core_data_q;
    core_sel_d  = core_sel_q;
    keyexp_en_d = keyexp_en_q;
    encdec_en_d = encdec_en_q;

    case (state_q)
      ST_IDLE: begin
        if (iReqA_valid || iReqB_valid) begin
          owner_d     = grant_b;
          rr_last_d   = grant_b;
          acc_a_d     = !grant_b;
          acc_b_d     = grant_b;
          core_key_d  = grant_key;
          core_data_d = grant_b ? iReqB_data : iReqA_data;
          core_sel_d  = grant_b ? iReqB_sel : iReqA_sel;
          timer_d     = '0;
          err_d       = 1'b0;
          if (key_valid_q && (grant_key == cache_key_q)) begin
            state_d     = ST_CRYPT;
            encdec_en_d = 1'b1;
          end else begin
            state_d     = ST_KEYEXP;
            keyexp_en_d = 1'b1;
            key_valid_d = 1'b0;
          end
        end
      end
      ST_KEYEXP: begin
        if (iCore_keyexp_ready) begin
          cache_key_d = core_key_q;
          key_valid_d = 1'b1;
          keyexp_en_d = 1'b0;
          encdec_en_d = 1'b1;
          timer_d     = '0;
          state_d     = ST_CRYPT;
        end else if (timer_hit) begin
          keyexp_en_d = 1'b0;
          key_valid_d = 1'b0;
          result_d    = '0;
          err_d       = 1'b1;
          state_d     = ST_RESP;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      ST_CRYPT: begin
        if (iCore_ready) begin
          result_d    = iCore_result;
          err_d       = 1'b0;
          encdec_en_d = 1'b0;
          state_d     = ST_RESP;
        end else if (timer_hit) begin
          encdec_en_d = 1'b0;
          key_valid_d = 1'b0;
          result_d    = '0;
          err_d       = 1'b1;
          state_d     = ST_RESP;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: begin
        resp_a_d    = !owner_q;
        resp_b_d    = owner_q;
        resp_data_d = result_q;
        resp_err_d  = err_q;
        state_d     = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      state_q     <= ST_IDLE;
      owner_q     <= 1'b0;
      rr_last_q   <= 1'b1;
      key_valid_q <= 1'b0;
      cache_key_q <= '0;
      timer_q     <= '0;
      result_q    <= '0;
      err_q       <= 1'b0;
      acc_a_q     <= 1'b0;
      acc_b_q     <= 1'b0;
      resp_a_q    <= 1'b0;
      resp_b_q    <= 1'b0;
      resp_data_q <= '0;
      resp_err_q  <= 1'b0;
      core_key_q  <= '0;
      core_data_q <= '0;
      core_sel_q  <= 1'b0;
      keyexp_en_q <= 1'b0;
      encdec_en_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_last_q   <= rr_last_d;
      key_valid_q <= key_valid_d;
      cache_key_q <= cache_key_d;
      timer_q     <= timer_d;
      result_q    <= result_d;
      err_q       <= err_d;
      acc_a_q     <= acc_a_d;
      acc_b_q     <= acc_b_d;
      resp_a_q    <= resp_a_d;
      resp_b_q    <= resp_b_d;
      resp_data_q <= resp_data_d;
      resp_err_q  <= resp_err_d;
      core_key_q  <= core_key_d;
      core_data_q <= core_data_d;
      core_sel_q  <= core_sel_d;
      keyexp_en_q <= keyexp_en_d;
      encdec_en_q <= encdec_en_d;
      busy_q      <= busy_d;
    end
  end

  assign oReqA_accept    = acc_a_q;
  assign oReqB_accept    = acc_b_q;
  assign oRespA_valid    = resp_a_q;
  assign oRespB_valid    = resp_b_q;
  assign oResp_data      = resp_data_q;
  assign oResp_err       = resp_err_q;
  assign oCore_key       = core_key_q;
  assign oCore_data      = core_data_q;
  assign oCore_sel       = core_sel_q;
  assign oCore_keyexp_en = keyexp_en_q;
  assign oCore_encdec_en = encdec_en_q;
  assign oBusy           = busy_q;
  assign oKey_cached     = key_valid_q;

endmodule

// File: tb/tb_sm4_req_scheduler.sv
// Randomized bench for sm4_req_scheduler: a stand-in SM4 core with random
// latencies plus a job-level scoreboard for grant order, cache use and timing.
module tb_sm4_req_scheduler;

  localparam int TO = 16;
  localparam logic [127:0] KV = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] CV = 128'h681edf34d206965e86b3e94f536e4246;

  logic         iClk = 1'b0;
  logic         iReset_n;
  logic         iReqA_valid, iReqB_valid, iReqA_sel, iReqB_sel;
  logic [127:0] iReqA_key, iReqA_data, iReqB_key, iReqB_data;
  logic         oReqA_accept, oReqB_accept, oRespA_valid, oRespB_valid;
  logic [127:0] oResp_data, oCore_key, oCore_data;
  logic         oResp_err, oCore_sel, oCore_keyexp_en, oCore_encdec_en;
  logic         iCore_keyexp_ready, iCore_ready;
  logic [127:0] iCore_result;
  logic         oBusy, oKey_cached;

  sm4_req_scheduler #(.TIMEOUT_CYCLES(TO)) dut (
    .iClk(iClk), .iReset_n(iReset_n),
    .iReqA_valid(iReqA_valid), .iReqA_key(iReqA_key), .iReqA_data(iReqA_data), .iReqA_sel(iReqA_sel),
    .iReqB_valid(iReqB_valid), .iReqB_key(iReqB_key), .iReqB_data(iReqB_data), .iReqB_sel(iReqB_sel),
    .oReqA_accept(oReqA_accept), .oReqB_accept(oReqB_accept),
    .oRespA_valid(oRespA_valid), .oRespB_valid(oRespB_valid),
    .oResp_data(oResp_data), .oResp_err(oResp_err),
    .oCore_key(oCore_key), .oCore_data(oCore_data), .oCore_sel(oCore_sel),
    .oCore_keyexp_en(oCore_keyexp_en), .oCore_encdec_en(oCore_encdec_en),
    .iCore_keyexp_ready(iCore_keyexp_ready), .iCore_ready(iCore_ready), .iCore_result(iCore_result),
    .oBusy(oBusy), .oKey_cached(oKey_cached)
  );

  initial forever #5 iClk = ~iClk;

  int n_vec = 0, n_bad = 0, cyc = 0, n_jobs = 0;

  // Requester inputs as they stand going into the next rising edge
  logic         snap_va, snap_vb, snap_sa, snap_sb;
  logic [127:0] snap_ka, snap_da, snap_kb, snap_db;

  // Reference model state
  bit           idle_flag, job_active, m_cv, m_last;
  logic [127:0] m_ck;
  bit           j_owner, j_miss, j_to, j_sel;
  logic [127:0] j_key, j_data;
  int           j_acc, j_lk, j_lc, j_kx_seen, cr_entry;
  int           kx_cnt, cr_cnt, force_lk, a_more, b_more;
  bit           core_hold, stale;
  logic [127:0] pool [3];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Stand-in for the SM4 core: the known vector both ways, anything else a keyed scramble
  function automatic logic [127:0] core_fn(input logic [127:0] k, input logic [127:0] d, input logic s);
    if (k == KV && !s && d == KV) return CV;
    if (k == KV && s && d == CV) return KV;
    return k ^ {d[63:0], d[127:64]} ^ {128{s}};
  endfunction

  task automatic load_a(input logic [127:0] k, input logic [127:0] d, input logic s);
    iReqA_key = k; iReqA_data = d; iReqA_sel = s; iReqA_valid = 1'b1;
  endtask

  task automatic load_b(input logic [127:0] k, input logic [127:0] d, input logic s);
    iReqB_key = k; iReqB_data = d; iReqB_sel = s; iReqB_valid = 1'b1;
  endtask

  task automatic model_reset();
    idle_flag = 1; job_active = 0; m_cv = 0; m_last = 1; m_ck = '0;
    kx_cnt = 0; cr_cnt = 0; a_more = 0; b_more = 0; j_kx_seen = 0;
    iReqA_valid = 0; iReqB_valid = 0; iCore_keyexp_ready = 0; iCore_ready = 0; iCore_result = '0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctl"}, {oReqA_accept, oReqB_accept, oRespA_valid, oRespB_valid, oResp_err,
                          oCore_sel, oCore_keyexp_en, oCore_encdec_en, oBusy, oKey_cached}, '0);
    check({tag, "_rdata"}, oResp_data, '0);
    check({tag, "_ckey"}, oCore_key, '0);
    check({tag, "_cdata"}, oCore_data, '0);
  endtask

  task automatic do_reset();
    #2 iReset_n = 1'b0;
    #1 check_all_zero("async_reset");
    model_reset();
    @(negedge iClk);
    iReset_n = 1'b1;
  endtask

  task automatic tick();
    logic acc_any, resp_any;
    bit gb;
    logic [127:0] exp_res;
    snap_va = iReqA_valid; snap_vb = iReqB_valid; snap_sa = iReqA_sel; snap_sb = iReqB_sel;
    snap_ka = iReqA_key; snap_da = iReqA_data; snap_kb = iReqB_key; snap_db = iReqB_data;
    @(negedge iClk);
    cyc++;
    if (!iReset_n) return;
    acc_any  = oReqA_accept | oReqB_accept;
    resp_any = oRespA_valid | oRespB_valid;
    if (acc_any && resp_any) check("accept_resp_overlap", 1'b1, 1'b0);

    if (idle_flag && (snap_va || snap_vb)) begin
      gb = snap_vb && (!snap_va || !m_last);
      check("accept_owner", {oReqB_accept, oReqA_accept}, gb ? 2'b10 : 2'b01);
      j_owner = gb; m_last = gb;
      j_key = gb ? snap_kb : snap_ka; j_data = gb ? snap_db : snap_da; j_sel = gb ? snap_sb : snap_sa;
      j_miss = !(m_cv && m_ck == j_key);
      if (j_miss) m_cv = 0;
      j_to = core_hold; j_acc = cyc; j_kx_seen = 0;
      j_lk = (force_lk > 0) ? force_lk : int'($urandom_range(1, 6));
      j_lc = int'($urandom_range(1, 6));
      check("core_key", oCore_key, j_key);
      check("core_data", oCore_data, j_data);
      check("core_sel", oCore_sel, j_sel);
      check("core_enables", {oCore_keyexp_en, oCore_encdec_en}, j_miss ? 2'b10 : 2'b01);
      check("busy_at_accept", oBusy, 1'b1);
      idle_flag = 0; job_active = 1;
      if (gb) begin
        if (b_more > 0) begin b_more--; load_b(rand128(), rand128(), 1'($urandom)); end
        else iReqB_valid = 0;
      end else begin
        if (a_more > 0) begin a_more--; load_a(rand128(), rand128(), 1'($urandom)); end
        else iReqA_valid = 0;
      end
    end else if (acc_any) begin
      check("unexpected_accept", {oReqB_accept, oReqA_accept}, 2'b00);
    end

    if (resp_any) begin
      if (!job_active) begin
        check("unexpected_resp", {oRespB_valid, oRespA_valid}, 2'b00);
      end else begin
        exp_res = j_to ? '0 : core_fn(j_key, j_data, j_sel);
        if (j_to) m_cv = 0;
        check("resp_owner", {oRespB_valid, oRespA_valid}, j_owner ? 2'b10 : 2'b01);
        check("resp_data", oResp_data, exp_res);
        check("resp_err", oResp_err, j_to);
        if (j_to) check("timeout_latency", cyc - cr_entry, TO);
        else      check("resp_latency", cyc - j_acc, (j_miss ? j_lk : 0) + j_lc + 1);
        check("keyexp_cycles", j_kx_seen, j_miss ? j_lk : 0);
        check("key_cached", oKey_cached, m_cv);
        check("busy_at_resp", oBusy, 1'b0);
        n_jobs++;
        $display("job %0d: owner=%s sel=%0d miss=%0d err=%0d lat=%0d data=%h",
                 n_jobs, j_owner ? "B" : "A", j_sel, j_miss, j_to, cyc - j_acc, oResp_data);
        job_active = 0; idle_flag = 1;
      end
    end

    if (oCore_keyexp_en) begin
      kx_cnt++; j_kx_seen++;
      iCore_keyexp_ready = (kx_cnt == j_lk);
      if (iCore_keyexp_ready) begin m_cv = 1; m_ck = j_key; end
    end else begin
      kx_cnt = 0; iCore_keyexp_ready = 0;
    end
    if (oCore_encdec_en) begin
      if (cr_cnt == 0) cr_entry = cyc;
      cr_cnt++;
      iCore_ready  = !core_hold && (cr_cnt == j_lc);
      iCore_result = core_fn(oCore_key, oCore_data, oCore_sel);
    end else begin
      cr_cnt = 0; iCore_ready = stale; iCore_result = rand128();
    end
  endtask

  task automatic run_until_quiet(input int budget);
    int n = 0;
    while ((job_active || iReqA_valid || iReqB_valid) && n < budget) begin
      tick();
      n++;
    end
    check("quiet_within_budget", {job_active, iReqA_valid, iReqB_valid}, 3'b000);
  endtask

  initial begin
    iReset_n = 1'b0;
    iReqA_key = '0; iReqA_data = '0; iReqA_sel = 0; iReqB_key = '0; iReqB_data = '0; iReqB_sel = 0;
    core_hold = 0; stale = 0; force_lk = 0;
    model_reset();
    pool[0] = KV; pool[1] = rand128(); pool[2] = rand128();
    repeat (2) @(negedge iClk);
    check_all_zero("reset_state");
    iReset_n = 1'b1;

    // Known-vector encrypt on A, then decrypt on B reusing the cached key
    load_a(KV, KV, 1'b0);
    run_until_quiet(100);
    load_b(KV, CV, 1'b1);
    run_until_quiet(100);

    // Contention straight out of reset, two jobs per side with fresh keys
    tick();
    do_reset();
    load_a(rand128(), rand128(), 1'b0);
    load_b(rand128(), rand128(), 1'b1);
    a_more = 1; b_more = 1;
    run_until_quiet(200);

    // Crypt phase never completes; the repeat job with the same key must re-expand
    core_hold = 1;
    load_a(pool[1], rand128(), 1'b0);
    run_until_quiet(100);
    core_hold = 0;
    tick();
    load_a(pool[1], rand128(), 1'b1);
    run_until_quiet(100);

    // Reset while key expansion is in progress, then a normal job
    force_lk = 12;
    load_a(rand128(), rand128(), 1'b0);
    repeat (3) tick();
    check("keyexp_before_reset", oCore_keyexp_en, 1'b1);
    do_reset();
    force_lk = 0;
    repeat (2) tick();
    load_a(KV, KV, 1'b0);
    run_until_quiet(100);

    // Stale core ready while idle
    stale = 1;
    repeat (5) tick();
    load_b(pool[2], rand128(), 1'b0);
    run_until_quiet(100);
    stale = 0;

    // Random mix over a small key pool so hits and misses both occur
    for (int i = 0; i < 40; i++) begin
      if (!iReqA_valid && ($urandom % 2 == 0)) load_a(pool[$urandom % 3], rand128(), 1'($urandom));
      if (!iReqB_valid && ($urandom % 2 == 0)) load_b(pool[$urandom % 3], rand128(), 1'($urandom));
      repeat ($urandom_range(1, 8)) tick();
    end
    run_until_quiet(300);
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
